// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2-read/1-write register file with zero-fill sweep
//
// Purpose: operand storage with one synchronous write port, two combinational
// read ports, an optional write-to-read bypass and a sweep that zero-fills
// the whole array after reset or whenever clr is requested.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   clr         synchronous request to restart the zero-fill sweep
//   we          write enable
//   address_w   write address
//   data_w      write data
//   address_r0  read port 0 address
//   address_r1  read port 1 address
//   data_r0     read port 0 data (combinational)
//   data_r1     read port 1 data (combinational)
//   busy        high while the sweep runs
//   wr_err      one-cycle pulse per dropped write
module reg_file_2r1w #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address_w,
  input  logic [DATA_WIDTH-1:0] data_w,
  input  logic [ADDR_WIDTH-1:0] address_r0,
  input  logic [ADDR_WIDTH-1:0] address_r1,
  output logic [DATA_WIDTH-1:0] data_r0,
  output logic [DATA_WIDTH-1:0] data_r1,
  output logic                  busy,
  output logic                  wr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
  logic                  r_wr_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_busy;
  logic w_user_we;
  logic w_drop;

  assign w_busy = (r_state == S_CLEAR);
  // A clr sampled in IDLE turns the same edge into the start of a sweep,
  // so a write presented alongside it is dropped as well.
  assign w_user_we = we && !w_busy && !clr;
  assign w_drop    = we && (w_busy || clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_wr_err   <= w_drop;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    if (clr) begin
      // Restart wins over sweep completion.
      w_state_nxt    = S_CLEAR;
      w_clr_addr_nxt = '0;
    end else if (r_state == S_CLEAR) begin
      w_clr_addr_nxt = r_clr_addr + ADDR_ONE;
      if (r_clr_addr == ADDR_LAST) begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // The array has no reset; gating on reset keeps an edge coincident with
  // reset assertion from writing anything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_busy) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_user_we) begin
        r_mem[address_w] <= data_w;
      end
    end
  end

  always_comb begin
    data_r0 = r_mem[address_r0];
    if (w_busy) begin
      data_r0 = '0;
    end else if ((BYPASS != 0) && we && (address_r0 == address_w)) begin
      data_r0 = data_w;
    end
  end

  always_comb begin
    data_r1 = r_mem[address_r1];
    if (w_busy) begin
      data_r1 = '0;
    end else if ((BYPASS != 0) && we && (address_r1 == address_w)) begin
      data_r1 = data_w;
    end
  end

  assign busy   = w_busy;
  assign wr_err = r_wr_err;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - scoreboard bench for reg_file_2r1w
module tb_reg_file_2r1w;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       we;
  logic [2:0] address_w;
  logic [7:0] data_w;
  logic [2:0] address_r0;
  logic [2:0] address_r1;
  logic [7:0] b1_r0, b1_r1, b0_r0, b0_r1;
  logic       b1_busy, b1_err, b0_busy, b0_err;

  reg_file_2r1w #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .BYPASS(1)) u_byp1 (
    .clk(clk), .reset(reset), .clr(clr), .we(we),
    .address_w(address_w), .data_w(data_w),
    .address_r0(address_r0), .address_r1(address_r1),
    .data_r0(b1_r0), .data_r1(b1_r1), .busy(b1_busy), .wr_err(b1_err)
  );

  reg_file_2r1w #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .BYPASS(0)) u_byp0 (
    .clk(clk), .reset(reset), .clr(clr), .we(we),
    .address_w(address_w), .data_w(data_w),
    .address_r0(address_r0), .address_r1(address_r1),
    .data_r0(b0_r0), .data_r1(b0_r1), .busy(b0_busy), .wr_err(b0_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observable points checked by the monitor.
  localparam int K_B1_R0   = 0;
  localparam int K_B1_R1   = 1;
  localparam int K_B0_R0   = 2;
  localparam int K_B0_R1   = 3;
  localparam int K_B1_BUSY = 4;
  localparam int K_B1_ERR  = 5;
  localparam int K_B0_BUSY = 6;
  localparam int K_B0_ERR  = 7;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_val(input int kind, input logic [7:0] v, input string tag);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.tag  = tag;
    q.push_back(e);
  endtask

  task automatic expect_status(input logic bz, input logic er, input string tag);
    expect_val(K_B1_BUSY, {7'd0, bz}, {tag, "_busy1"});
    expect_val(K_B0_BUSY, {7'd0, bz}, {tag, "_busy0"});
    expect_val(K_B1_ERR,  {7'd0, er}, {tag, "_err1"});
    expect_val(K_B0_ERR,  {7'd0, er}, {tag, "_err0"});
  endtask

  // Inputs change 1ns after the rising edge; the monitor samples on the
  // falling edge, so each cycle's expectations are compared mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = q.pop_front();
      case (e.kind)
        K_B1_R0:   act = b1_r0;
        K_B1_R1:   act = b1_r1;
        K_B0_R0:   act = b0_r0;
        K_B0_R1:   act = b0_r1;
        K_B1_BUSY: act = {7'd0, b1_busy};
        K_B1_ERR:  act = {7'd0, b1_err};
        K_B0_BUSY: act = {7'd0, b0_busy};
        default:   act = {7'd0, b0_err};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", e.tag, act, e.exp, $time);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      address_r0 = 3'(a);
      address_r1 = 3'(7 - a);
      expect_val(K_B1_R0, 8'h00, {tag, "_r0"});
      expect_val(K_B1_R1, 8'h00, {tag, "_r1"});
      expect_val(K_B0_R0, 8'h00, {tag, "_b0r0"});
      expect_val(K_B0_R1, 8'h00, {tag, "_b0r1"});
      step();
    end
  endtask

  task automatic sweep_cycles(input string tag);
    for (int i = 0; i < 9; i++) begin
      expect_status((i < 8), 1'b0, tag);
      step();
    end
  endtask

  initial begin
    reset      = 1'b1;
    clr        = 1'b0;
    we         = 1'b0;
    address_w  = 3'd0;
    data_w     = 8'h00;
    address_r0 = 3'd0;
    address_r1 = 3'd0;

    // Reset state
    step();
    step();
    expect_status(1'b1, 1'b0, "reset_hold");
    expect_val(K_B1_R0, 8'h00, "reset_r0");
    step();

    // Reset release: busy for exactly 8 cycles
    reset = 1'b0;
    sweep_cycles("reset_sweep");
    check_all_zero("after_reset");

    // Write/read with bypass
    address_r0 = 3'd3;
    address_r1 = 3'd6;
    we = 1'b1; address_w = 3'd3; data_w = 8'hA5;
    expect_val(K_B1_R0, 8'hA5, "byp_wr3_r0");
    expect_val(K_B1_R1, 8'h00, "byp_wr3_r1");
    expect_val(K_B0_R0, 8'h00, "nobyp_wr3_r0");
    step();
    address_w = 3'd6; data_w = 8'h5A;
    expect_val(K_B1_R0, 8'hA5, "byp_wr6_r0");
    expect_val(K_B1_R1, 8'h5A, "byp_wr6_r1");
    expect_val(K_B0_R0, 8'hA5, "nobyp_wr6_r0");
    expect_val(K_B0_R1, 8'h00, "nobyp_wr6_r1");
    step();
    we = 1'b0;
    expect_val(K_B1_R0, 8'hA5, "stored3_r0");
    expect_val(K_B1_R1, 8'h5A, "stored6_r1");
    expect_val(K_B0_R0, 8'hA5, "stored3_b0r0");
    expect_val(K_B0_R1, 8'h5A, "stored6_b0r1");
    step();

    // Same-cycle collision, bypass off vs on
    we = 1'b1; address_w = 3'd2; data_w = 8'h11;
    step();
    address_r0 = 3'd2; address_r1 = 3'd2; data_w = 8'h22;
    expect_val(K_B0_R0, 8'h11, "coll_old_b0r0");
    expect_val(K_B1_R0, 8'h22, "coll_new_b1r0");
    expect_val(K_B1_R1, 8'h22, "coll_new_b1r1");
    step();
    we = 1'b0;
    expect_val(K_B0_R0, 8'h22, "coll_after_b0r0");
    expect_val(K_B0_R1, 8'h22, "coll_after_b0r1");
    step();

    // Fill with 0xFF, clr, clr again mid-sweep
    we = 1'b1; data_w = 8'hFF;
    for (int a = 0; a < 8; a++) begin
      address_w = 3'(a);
      step();
    end
    we = 1'b0;
    address_r0 = 3'd4;
    address_r1 = 3'd0;
    expect_val(K_B1_R0, 8'hFF, "fill_r0");
    expect_val(K_B0_R1, 8'hFF, "fill_b0r1");
    step();
    clr = 1'b1;
    expect_status(1'b0, 1'b0, "clr1_cycle");
    expect_val(K_B1_R0, 8'hFF, "clr1_cycle_r0");
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_status(1'b1, 1'b0, "clr1_sweep");
      expect_val(K_B1_R0, 8'h00, "clr1_sweep_r0");
      step();
    end
    clr = 1'b1;
    expect_status(1'b1, 1'b0, "clr2_cycle");
    step();
    clr = 1'b0;
    sweep_cycles("clr2_sweep");
    check_all_zero("after_clr");

    // Dropped writes during the sweep
    clr = 1'b1;
    step();
    clr = 1'b0;
    address_w = 3'd5; data_w = 8'h77;
    for (int i = 0; i < 9; i++) begin
      we = (i < 2);
      expect_status((i < 8), (i == 1 || i == 2), "drop");
      step();
    end
    address_r0 = 3'd5;
    address_r1 = 3'd5;
    expect_val(K_B1_R0, 8'h00, "drop_addr5_r0");
    expect_val(K_B0_R1, 8'h00, "drop_addr5_b0r1");
    step();

    // Async reset mid-sweep
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    we = 1'b1;
    step();
    we = 1'b0;
    #2;
    reset = 1'b1;
    expect_status(1'b1, 1'b0, "async_rst");
    step();
    reset = 1'b0;
    sweep_cycles("rst_sweep");
    check_all_zero("after_rst");

    step();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
